// File: rtl/scp_core_if.sv
// Bus between the single-cycle core and its instruction/data memories.
// The core is the master: it drives PC and the data-memory request, the memories answer combinationally.
interface scp_core_if;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   modport master (
      output PC,
      output MemWrite,
      output ALUResult,
      output WriteData,
      input  Instr,
      input  ReadData
   );

   modport slave (
      input  PC,
      input  MemWrite,
      input  ALUResult,
      input  WriteData,
      output Instr,
      output ReadData
   );
endinterface

// File: rtl/scp_core.sv
// Single-cycle RV32I-subset core: lw, sw, R-type add/sub/and/or/slt, addi/andi/ori/slti, beq, jal.
// Every instruction is decoded, executed and retired in the cycle it is presented on Instr.
module scp_core (
   input  logic       clk,
   input  logic       reset,
   scp_core_if.master bus
);

   typedef enum logic [6:0] {
      OP_LW  = 7'b0000011,
      OP_SW  = 7'b0100011,
      OP_R   = 7'b0110011,
      OP_I   = 7'b0010011,
      OP_BEQ = 7'b1100011,
      OP_JAL = 7'b1101111
   } opcode_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_ZERO
   } alu_op_t;

   logic [31:0] pc;
   logic [31:0] regs [32];

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        is_lw, is_sw, is_r, is_i, is_beq, is_jal;
   logic [31:0] imm_i, imm_s, imm_b, imm_j;
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] src_b;
   alu_op_t     alu_op;
   logic [31:0] alu_result;
   logic        reg_write;
   logic [31:0] result;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;

   assign opcode = bus.Instr[6:0];
   assign funct3 = bus.Instr[14:12];
   assign rs1    = bus.Instr[19:15];
   assign rs2    = bus.Instr[24:20];
   assign rd     = bus.Instr[11:7];

   assign is_lw  = (opcode == OP_LW);
   assign is_sw  = (opcode == OP_SW);
   assign is_r   = (opcode == OP_R);
   assign is_i   = (opcode == OP_I);
   assign is_beq = (opcode == OP_BEQ);
   assign is_jal = (opcode == OP_JAL);

   assign imm_i = {{20{bus.Instr[31]}}, bus.Instr[31:20]};
   assign imm_s = {{20{bus.Instr[31]}}, bus.Instr[31:25], bus.Instr[11:7]};
   assign imm_b = {{20{bus.Instr[31]}}, bus.Instr[7], bus.Instr[30:25], bus.Instr[11:8], 1'b0};
   assign imm_j = {{12{bus.Instr[31]}}, bus.Instr[19:12], bus.Instr[20], bus.Instr[30:21], 1'b0};

   // x0 is forced to zero on read so it never depends on the array contents
   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

   always_comb begin
      src_b = imm_i;
      if (is_r || is_beq) begin
         src_b = rs2_val;
      end else if (is_sw) begin
         src_b = imm_s;
      end else if (is_jal) begin
         src_b = imm_j;
      end
   end

   // Only R-type honours Instr[30] as sub; addi with a negative immediate must still add
   always_comb begin
      alu_op = ALU_ADD;
      if (is_beq) begin
         alu_op = ALU_SUB;
      end else if (is_r || is_i) begin
         case (funct3)
            3'b000:  alu_op = (is_r && bus.Instr[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ZERO;
         endcase
      end
   end

   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         ALU_ADD:  alu_result = rs1_val + src_b;
         ALU_SUB:  alu_result = rs1_val - src_b;
         ALU_AND:  alu_result = rs1_val & src_b;
         ALU_OR:   alu_result = rs1_val | src_b;
         ALU_SLT:  alu_result = {31'd0, ($signed(rs1_val) < $signed(src_b))};
         default:  alu_result = 32'd0;
      endcase
   end

   assign pc_plus4  = pc + 32'd4;
   assign reg_write = !reset && (is_r || is_i || is_lw || is_jal);

   always_comb begin
      result = alu_result;
      if (is_lw) begin
         result = bus.ReadData;
      end else if (is_jal) begin
         result = pc_plus4;
      end
   end

   always_comb begin
      next_pc = pc_plus4;
      if (is_jal) begin
         next_pc = pc + imm_j;
      end else if (is_beq && (alu_result == 32'd0)) begin
         next_pc = pc + imm_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= 32'd0;
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else begin
         pc <= next_pc;
         if (reg_write && (rd != 5'd0)) begin
            regs[rd] <= result;
         end
      end
   end

   assign bus.PC        = pc;
   assign bus.MemWrite  = is_sw && !reset;
   assign bus.ALUResult = alu_result;
   assign bus.WriteData = rs2_val;

endmodule

// File: tb/tb_scp_core.sv
// Bench for scp_core: a directed program followed by random instructions, all checked against
// an instruction-level model of the architectural state (PC and 32 registers).
module tb_scp_core;

   logic clk;
   logic reset;

   scp_core_if bus ();

   scp_core dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vectors = 0;
   int n_miscompares = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_pc;

   logic [31:0] e_alu, e_wd, e_npc, e_wval;
   logic        e_alu_ok, e_mw, e_wr;
   logic [4:0]  e_rd;
   logic        cur_rst;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_vectors++;
      if (observed !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (model pc %h)", tag, observed, expected, m_pc);
      end
   endtask

   // Architectural effect of one instruction, worked out mnemonic by mnemonic
   task automatic model_eval(input logic [31:0] ins, input logic [31:0] rdata, input logic rst);
      logic [31:0] a, b, imm_i, imm_s, imm_b, imm_j, opb;
      logic [2:0]  f3;
      a     = m_regs[ins[19:15]];
      b     = m_regs[ins[24:20]];
      f3    = ins[14:12];
      imm_i = 32'($signed(ins[31:20]));
      imm_s = 32'($signed({ins[31:25], ins[11:7]}));
      imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      e_alu_ok = 1'b1;
      e_alu    = 32'd0;
      e_mw     = 1'b0;
      e_wr     = 1'b0;
      e_rd     = ins[11:7];
      e_wval   = 32'd0;
      e_wd     = b;
      e_npc    = m_pc + 32'd4;
      case (ins[6:0])
         7'b0000011: begin
            e_alu = a + imm_i;
            e_wr = 1'b1;
            e_wval = rdata;
         end
         7'b0100011: begin
            e_alu = a + imm_s;
            e_mw = 1'b1;
         end
         7'b0110011, 7'b0010011: begin
            opb = (ins[6:0] == 7'b0110011) ? b : imm_i;
            case (f3)
               3'b000: e_alu = (ins[6:0] == 7'b0110011 && ins[30]) ? a - opb : a + opb;
               3'b010: e_alu = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
               3'b110: e_alu = a | opb;
               3'b111: e_alu = a & opb;
               default: e_alu = 32'd0;
            endcase
            e_wr = 1'b1;
            e_wval = e_alu;
         end
         7'b1100011: begin
            e_alu = a - b;
            if (a == b) e_npc = m_pc + imm_b;
         end
         7'b1101111: begin
            e_alu_ok = 1'b0;
            e_wr = 1'b1;
            e_wval = m_pc + 32'd4;
            e_npc = m_pc + imm_j;
         end
         default: e_alu_ok = 1'b0;
      endcase
      if (rst) begin
         e_mw = 1'b0;
         e_wr = 1'b0;
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] ins, input logic [31:0] rdata, input logic rst);
      bus.Instr    = ins;
      bus.ReadData = rdata;
      reset        = rst;
      cur_rst      = rst;
      #3;
      model_eval(ins, rdata, rst);
      check_output("pc", bus.PC, m_pc);
      check_output("memwrite", {31'd0, bus.MemWrite}, {31'd0, e_mw});
      check_output("writedata", bus.WriteData, e_wd);
      if (e_alu_ok) check_output("aluresult", bus.ALUResult, e_alu);
   endtask

   task automatic commit_edge();
      @(posedge clk);
      if (cur_rst) begin
         m_pc = 32'd0;
         foreach (m_regs[i]) m_regs[i] = 32'd0;
      end else begin
         if (e_wr && e_rd != 5'd0) m_regs[e_rd] = e_wval;
         m_pc = e_npc;
      end
      #1;
   endtask

   task automatic step(input logic [31:0] ins, input logic [31:0] rdata);
      apply_stimulus(ins, rdata, 1'b0);
      commit_edge();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] hi;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [31:0] ins;
      hi  = $urandom;
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
         0: f3 = 3'b000;
         1: f3 = 3'b010;
         2: f3 = 3'b110;
         3: f3 = 3'b111;
         default: f3 = 3'($urandom_range(0, 7));
      endcase
      case ($urandom_range(0, 9))
         0: ins = {hi[11:0], rs1, 3'b010, rd, 7'b0000011};
         1: ins = {hi[6:0], rs2, rs1, 3'b010, hi[11:7], 7'b0100011};
         2, 3: ins = {1'b0, hi[0], 5'd0, rs2, rs1, f3, rd, 7'b0110011};
         4, 5: ins = {hi[11:0], rs1, f3, rd, 7'b0010011};
         6: ins = {hi[6:0], rs2, (hi[31] ? rs2 : rs1), 3'b000, hi[11:7], 7'b1100011};
         7: ins = {hi[19:0], rd, 7'b1101111};
         8: ins = {hi[24:0], 7'b0110111};
         default: ins = $urandom;
      endcase
      return ins;
   endfunction

   initial begin
      reset        = 1'b1;
      cur_rst      = 1'b1;
      bus.Instr    = 32'd0;
      bus.ReadData = 32'd0;
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_pc = 32'd0;
      @(posedge clk);
      #1;

      // sw presented during reset must not write memory
      apply_stimulus(32'h00202223, 32'd0, 1'b1);
      check_output("tp_reset_pc", bus.PC, 32'd0);
      check_output("tp_reset_mw", {31'd0, bus.MemWrite}, 32'd0);
      commit_edge();

      apply_stimulus(32'h00500113, 32'd0, 1'b0);
      check_output("tp_addi5", bus.ALUResult, 32'd5);
      commit_edge();
      check_output("tp_pc4", bus.PC, 32'd4);
      step(32'h00500113, 32'd0);
      check_output("tp_pc8", bus.PC, 32'd8);

      apply_stimulus(32'h00C00193, 32'd0, 1'b0);
      check_output("tp_addi12", bus.ALUResult, 32'd12);
      commit_edge();
      apply_stimulus(32'hFF718393, 32'd0, 1'b0);
      check_output("tp_addi_neg", bus.ALUResult, 32'd3);
      commit_edge();
      apply_stimulus(32'h0023E233, 32'd0, 1'b0);
      check_output("tp_or", bus.ALUResult, 32'd7);
      commit_edge();
      apply_stimulus(32'h0041F2B3, 32'd0, 1'b0);
      check_output("tp_and", bus.ALUResult, 32'd4);
      commit_edge();

      apply_stimulus(32'h02728863, 32'd0, 1'b0);
      check_output("tp_beq_nt_alu", bus.ALUResult, 32'd1);
      commit_edge();
      check_output("tp_beq_nt_pc", bus.PC, 32'h1C);

      apply_stimulus(32'h00202223, 32'd0, 1'b0);
      check_output("tp_sw_mw", {31'd0, bus.MemWrite}, 32'd1);
      check_output("tp_sw_addr", bus.ALUResult, 32'd4);
      check_output("tp_sw_data", bus.WriteData, 32'd5);
      commit_edge();

      step(32'h010000EF, 32'd0);
      check_output("tp_jal_pc", bus.PC, 32'h30);

      apply_stimulus(32'h0041A233, 32'd0, 1'b0);
      check_output("tp_slt", bus.ALUResult, 32'd0);
      commit_edge();
      step(32'h00020463, 32'd0);
      check_output("tp_beq_t_pc", bus.PC, 32'h3C);

      apply_stimulus(32'h00402303, 32'hDEADBEEF, 1'b0);
      check_output("tp_lw_mw", {31'd0, bus.MemWrite}, 32'd0);
      commit_edge();
      step(32'h00500013, 32'd0);

      apply_stimulus(32'h00602023, 32'd0, 1'b0);
      check_output("tp_x6", bus.WriteData, 32'hDEADBEEF);
      commit_edge();
      apply_stimulus(32'h00102023, 32'd0, 1'b0);
      check_output("tp_x1", bus.WriteData, 32'h24);
      commit_edge();
      apply_stimulus(32'h00002023, 32'd0, 1'b0);
      check_output("tp_x0", bus.WriteData, 32'd0);
      commit_edge();

      apply_stimulus(32'h123452B7, 32'd0, 1'b0);
      check_output("tp_unsup_mw", {31'd0, bus.MemWrite}, 32'd0);
      commit_edge();
      check_output("tp_unsup_pc", bus.PC, 32'h54);
      apply_stimulus(32'h00502023, 32'd0, 1'b0);
      check_output("tp_unsup_x5", bus.WriteData, 32'd4);
      commit_edge();

      apply_stimulus(32'h00502023, 32'd0, 1'b1);
      commit_edge();
      apply_stimulus(32'h00502023, 32'd0, 1'b0);
      check_output("tp_midreset_pc", bus.PC, 32'd0);
      check_output("tp_midreset_x5", bus.WriteData, 32'd0);
      commit_edge();

      for (int n = 0; n < 600; n++) begin
         apply_stimulus(rand_instr(), $urandom, ($urandom_range(0, 49) == 0));
         commit_edge();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
